// File: rtl/tdc_sampler.sv
// -----------------------------------------------------------------------------
// tdc_sampler
//
// Capture and averaging stage for a delay-line time-to-digital sensor.
// The raw tap vector of the delay chain is synchronised, decoded from a
// thermometer code to a binary count, and 2^LOG_SAMPLES consecutive codes are
// accumulated into one measurement reporting average, minimum and maximum.
//
// Ports:
//   clk         system clock, taps captured on the rising edge
//   rst         asynchronous, active-high reset
//   en          block enable; low aborts any measurement in progress
//   start       level-sampled request to begin a measurement (IDLE only)
//   continuous  1 = rearm automatically after each result (sampled in DONE)
//   taps        raw delay-line tap levels, bit i = edge has passed tap i
//   code        live decoded code (popcount of synchronised taps)
//   busy        high while a measurement is in progress
//   valid       one-cycle pulse when avg/min_code/max_code carry a new result
//   avg         truncated mean of the last measurement
//   min_code    smallest code in the last measurement
//   max_code    largest code in the last measurement
//   bubble_err  sticky: a non-thermometer pattern was accumulated
//   fsm_state   current FSM state (debug visibility)
//
// Handshake: valid is a single-cycle strobe with no back-pressure; the result
// registers hold their value until the next valid pulse, so a consumer may
// capture them on the strobe or at any time afterwards.
// -----------------------------------------------------------------------------
module tdc_sampler #(
    parameter int N_TAPS      = 16,
    parameter int LOG_SAMPLES = 4,
    parameter int SYNC_STAGES = 2,
    localparam int CW         = $clog2(N_TAPS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              continuous,
    input  logic [N_TAPS-1:0] taps,
    output logic [CW-1:0]     code,
    output logic              busy,
    output logic              valid,
    output logic [CW-1:0]     avg,
    output logic [CW-1:0]     min_code,
    output logic [CW-1:0]     max_code,
    output logic              bubble_err,
    output logic [1:0]        fsm_state
);

    localparam int AW      = CW + LOG_SAMPLES;          // accumulator cannot overflow
    localparam int CNT_W   = LOG_SAMPLES + 1;
    localparam int SAMPLES = 1 << LOG_SAMPLES;
    localparam int FW      = $clog2(SYNC_STAGES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_ACCUM = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Synchroniser: element 0 is the newest stage.
    logic [SYNC_STAGES-1:0][N_TAPS-1:0] sync_q;
    logic [N_TAPS-1:0]                  synced;

    logic [CW-1:0]    pop;
    logic [N_TAPS:0]  ext;
    logic             is_therm;
    logic             bub_q;

    logic [1:0]       state;
    logic [FW-1:0]    flush_cnt;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_next;
    logic [CW-1:0]    min_run;
    logic [CW-1:0]    max_run;
    logic [CW-1:0]    min_next;
    logic [CW-1:0]    max_next;
    logic [CNT_W-1:0] cnt;
    logic             last_sample;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], taps};
        end
    end

    // Thermometer decode. A legal pattern 2^k-1 has no set bit above a clear
    // one, so adding one to it carries cleanly into a single fresh bit and the
    // AND with the original is zero. The extra MSB absorbs the all-ones carry.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            pop = pop + CW'(synced[i]);
        end
        ext      = {1'b0, synced};
        is_therm = ((ext & (ext + (N_TAPS + 1)'(1))) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code  <= '0;
            bub_q <= 1'b0;
        end else begin
            code  <= pop;
            bub_q <= ~is_therm;
        end
    end

    // Running statistics including the sample currently on code.
    always_comb begin
        acc_next    = acc + AW'(code);
        min_next    = (code < min_run) ? code : min_run;
        max_next    = (code > max_run) ? code : max_run;
        last_sample = (cnt == CNT_W'(SAMPLES - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            flush_cnt  <= '0;
            acc        <= '0;
            min_run    <= '0;
            max_run    <= '0;
            cnt        <= '0;
            avg        <= '0;
            min_code   <= '0;
            max_code   <= '0;
            bubble_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en && start) begin
                        state      <= S_FLUSH;
                        flush_cnt  <= '0;
                        acc        <= '0;
                        min_run    <= '1;
                        max_run    <= '0;
                        cnt        <= '0;
                        bubble_err <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    // Drain the synchroniser and decode register so no sample
                    // from before the request reaches the accumulator.
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (flush_cnt == FW'(SYNC_STAGES)) begin
                        state <= S_ACCUM;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                S_ACCUM: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else begin
                        acc     <= acc_next;
                        min_run <= min_next;
                        max_run <= max_next;
                        cnt     <= cnt + CNT_W'(1);
                        if (bub_q) begin
                            bubble_err <= 1'b1;
                        end
                        // Results are loaded on entry to DONE so that they are
                        // already stable while valid is high.
                        if (last_sample) begin
                            state    <= S_DONE;
                            avg      <= acc_next[AW-1:LOG_SAMPLES];
                            min_code <= min_next;
                            max_code <= max_next;
                        end
                    end
                end
                S_DONE: begin
                    // Rearm skips the flush: the pipeline already holds live
                    // data, only the DONE-cycle sample is dropped.
                    if (en && continuous) begin
                        state      <= S_ACCUM;
                        acc        <= '0;
                        min_run    <= '1;
                        max_run    <= '0;
                        cnt        <= '0;
                        bubble_err <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign valid     = (state == S_DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_tdc_sampler.sv
// -----------------------------------------------------------------------------
// tb_tdc_sampler
//
// Bench for tdc_sampler at default parameters. A behavioural model keeps the
// tap history per cycle and derives live code, busy window, valid timing and
// measurement results from the timing and arithmetic rules of the block.
// -----------------------------------------------------------------------------
module tb_tdc_sampler;

    localparam int N_TAPS      = 16;
    localparam int LOG_SAMPLES = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CW          = 5;
    localparam int NS          = 1 << LOG_SAMPLES;
    localparam int LAT         = SYNC_STAGES + 1;        // taps -> code
    localparam int FIRST       = SYNC_STAGES + 2 + NS;   // start cycle -> valid cycle
    localparam int HN          = 64;

    // ---------------- clock / reset / DUT ----------------
    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic              en         = 1'b0;
    logic              start      = 1'b0;
    logic              continuous = 1'b0;
    logic [N_TAPS-1:0] taps       = '0;
    logic [CW-1:0]     code;
    logic              busy;
    logic              valid;
    logic [CW-1:0]     avg;
    logic [CW-1:0]     min_code;
    logic [CW-1:0]     max_code;
    logic              bubble_err;
    logic [1:0]        fsm_state;

    always #5 clk = ~clk;

    tdc_sampler #(
        .N_TAPS      (N_TAPS),
        .LOG_SAMPLES (LOG_SAMPLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .continuous (continuous),
        .taps       (taps),
        .code       (code),
        .busy       (busy),
        .valid      (valid),
        .avg        (avg),
        .min_code   (min_code),
        .max_code   (max_code),
        .bubble_err (bubble_err),
        .fsm_state  (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int                checks = 0;
    int                errors = 0;
    int                n;                 // current cycle index since reset release
    logic [N_TAPS-1:0] hist [HN];         // taps driven in each cycle (ring)
    logic [31:0]       exp_q [$];         // expected valid cycles
    int                busy_from;
    int                busy_until;
    int                last_done;
    int                valid_cnt = 0;
    int                held_avg, held_min, held_max;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, n, got, exp);
        end
    endtask

    function automatic int ones(input logic [N_TAPS-1:0] v);
        int c = 0;
        for (int i = 0; i < N_TAPS; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic bit is_therm(input logic [N_TAPS-1:0] v);
        longint k = longint'(ones(v));
        return longint'(v) == ((longint'(1) << k) - 1);
    endfunction

    function automatic logic [N_TAPS-1:0] rand_taps();
        longint            k = longint'($urandom_range(0, N_TAPS));
        logic [N_TAPS-1:0] v = N_TAPS'((longint'(1) << k) - 1);
        if ($urandom_range(0, 7) == 0) v[$urandom_range(0, N_TAPS - 1)] ^= 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        n          = 0;
        for (int i = 0; i < HN; i++) hist[i] = '0;
        exp_q.delete();
        busy_from  = 1;
        busy_until = 0;
        last_done  = -100;
        held_avg   = 0;
        held_min   = 0;
        held_max   = 0;
    endtask

    function automatic bit exp_busy(input int c);
        return (c >= busy_from) && (c <= busy_until);
    endfunction

    // Compare every output against the model for the cycle just entered.
    task automatic check_outputs();
        bit exp_v;
        int sum, mn, mx, bub, c;
        chk("code", code, (n >= LAT) ? ones(hist[(n - LAT) % HN]) : 0);
        chk("busy", busy, exp_busy(n));
        exp_v = (exp_q.size() > 0) && (exp_q[0] == n);
        if (exp_v) begin
            void'(exp_q.pop_front());
            last_done = n;
            valid_cnt++;
            sum = 0; mn = N_TAPS; mx = 0; bub = 0;
            for (int j = 0; j < NS; j++) begin
                c   = ones(hist[(n - FIRST + 1 + j) % HN]);
                sum += c;
                if (c < mn) mn = c;
                if (c > mx) mx = c;
                if (!is_therm(hist[(n - FIRST + 1 + j) % HN])) bub = 1;
            end
            held_avg = sum / NS;
            held_min = mn;
            held_max = mx;
            chk("bubble_err", bubble_err, bub);
        end
        chk("valid", valid, exp_v);
        chk("avg", avg, held_avg);
        chk("min_code", min_code, held_min);
        chk("max_code", max_code, held_max);
    endtask

    // ---------------- driver tasks ----------------
    // Inputs for cycle n are final on entry; the model applies abort/rearm
    // rules for this cycle, then the clock advances and outputs are checked.
    task automatic tick(input logic [N_TAPS-1:0] t);
        taps         = t;
        hist[n % HN] = t;
        if (exp_busy(n)) begin
            if (!en) begin
                busy_until = n;
                exp_q.delete();
            end else if (n == last_done && continuous) begin
                exp_q.push_back(32'(n + NS + 1));
                busy_until = n + NS + 1;
            end
        end
        @(posedge clk);
        #1;
        n++;
        check_outputs();
    endtask

    task automatic tick_start(input logic [N_TAPS-1:0] t);
        start = 1'b1;
        if (en && !exp_busy(n)) begin
            busy_from  = n + 1;
            busy_until = n + FIRST;
            exp_q.push_back(32'(n + FIRST));
        end
        tick(t);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_code"}, code, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_valid"}, valid, 0);
        chk({pfx, "_avg"}, avg, 0);
        chk({pfx, "_min"}, min_code, 0);
        chk({pfx, "_max"}, max_code, 0);
        chk({pfx, "_bubble"}, bubble_err, 0);
        chk({pfx, "_state"}, fsm_state, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v0, len, drop;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        en  = 1'b1;

        // Constant mid-scale code, start at cycle 0 -> valid in cycle FIRST.
        v0 = valid_cnt;
        tick_start(16'h00FF);
        repeat (FIRST) tick(16'h00FF);
        chk("const_valids", valid_cnt - v0, 1);
        chk("const_avg", avg, 8);
        chk("const_min", min_code, 8);
        chk("const_max", max_code, 8);
        chk("const_bubble", bubble_err, 0);

        // Alternating low/high codes.
        tick_start(16'h000F);
        for (int k = 1; k <= FIRST; k++) tick((k % 2) ? 16'h0FFF : 16'h000F);
        chk("alt_avg", avg, 8);
        chk("alt_min", min_code, 4);
        chk("alt_max", max_code, 12);

        // Full scale, then empty line.
        tick_start(16'hFFFF);
        repeat (FIRST) tick(16'hFFFF);
        chk("full_avg", avg, 16);
        repeat (LAT) tick(16'h0000);
        chk("empty_code", code, 0);

        // One bubbled sample inside the window.
        tick_start(16'h00FF);
        for (int k = 1; k <= FIRST; k++) tick((k == 5) ? 16'h00F7 : 16'h00FF);
        chk("bub_set", bubble_err, 1);
        chk("bub_avg", avg, 7);
        tick_start(16'h00FF);
        chk("bub_clear", bubble_err, 0);
        repeat (FIRST) tick(16'h00FF);

        // Continuous mode, then abort mid-accumulation.
        continuous = 1'b1;
        v0 = valid_cnt;
        tick_start(16'h003F);
        repeat (FIRST - 1 + 2 * (NS + 1) + 5) tick(16'h003F);
        en = 1'b0;
        repeat (25) tick(16'h003F);
        chk("cont_valids", valid_cnt - v0, 3);
        chk("cont_avg_hold", avg, 6);
        chk("cont_idle", busy, 0);
        en = 1'b1;
        continuous = 1'b0;

        // Randomised measurements with random mode and random aborts.
        for (int m = 0; m < 8; m++) begin
            continuous = 1'($urandom_range(0, 1));
            tick_start(rand_taps());
            len  = $urandom_range(25, 60);
            drop = ($urandom_range(0, 2) == 0) ? $urandom_range(5, len - 1) : -1;
            for (int k = 0; k < len; k++) begin
                if (k == drop) en = 1'b0;
                tick(rand_taps());
            end
            en = 1'b1;
            continuous = 1'b0;
            for (int k = 0; k < 40 && n <= busy_until; k++) tick(rand_taps());
            tick(rand_taps());
        end

        // Asynchronous reset mid-accumulation, then a clean measurement whose
        // first cycle carries stale-looking data that must be flushed.
        tick_start(rand_taps());
        repeat (8) tick(rand_taps());
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tick_start(16'hFFFF);
        repeat (FIRST) tick(16'h0003);
        chk("post_rst_avg", avg, 2);
        chk("post_rst_max", max_code, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/tdc_sampler.md
Name: tdc_sampler

Overview:
- Parametrised capture and averaging stage for a delay-line time-to-digital sensor.
- Samples the tap vector of an N_TAPS inverter/buffer chain on every clk, synchronises it, and converts the thermometer code to a binary count.
- Accumulates 2^LOG_SAMPLES codes per measurement and reports average, minimum and maximum, in one-shot or continuous mode.
- Sits between the analog-ish delay chain instance and the user-facing output mux.

Parameters:
- N_TAPS, 16: number of delay-line taps sampled; CW = clog2(N_TAPS+1) is the code width.
- LOG_SAMPLES, 4: log2 of samples per measurement; range 0..8.
- SYNC_STAGES, 2: flop stages on taps before decode; minimum 2.

Ports:
- clk  in  1  system clock; taps captured on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  block enable; low aborts any measurement.
- start  in  1  level-sampled request to begin a measurement.
- continuous  in  1  1 = rearm automatically after each result.
- taps  in  N_TAPS  raw delay-line tap levels; bit i = 1 means the edge has passed tap i.
- code  out  CW  live decoded code (popcount of synchronised taps).
- busy  out  1  high while a measurement is in progress.
- valid  out  1  one-cycle pulse when avg/min_code/max_code update.
- avg  out  CW  truncated mean of the last measurement.
- min_code  out  CW  smallest code in the last measurement.
- max_code  out  CW  largest code in the last measurement.
- bubble_err  out  1  sticky: a non-thermometer pattern was seen during the measurement.

Behaviour:
- Reset (async, rst=1): all flops 0, including sync chain, state, accumulator, counters and all outputs; state=IDLE.
- Synchroniser: taps pass through SYNC_STAGES flops every cycle regardless of state.
- Decode: code = popcount(synced taps), registered. Latency from taps to code is SYNC_STAGES+1 cycles. code updates every cycle in all states.
- Bubble check: the synced vector is valid only if it equals 2^k-1 for k in 0..N_TAPS. Otherwise a registered bubble flag is raised alongside code. During ACCUM a flagged sample sets bubble_err. The sample is still accumulated using its popcount.
- States:
  - IDLE: busy=0. If en=1 and start=1, go to FLUSH. The same edge clears acc, sets min_run to all-ones and max_run to 0, clears sample count and clears bubble_err.
  - FLUSH: busy=1. Lasts exactly SYNC_STAGES+1 cycles to drain stale pipeline data, then go to ACCUM.
  - ACCUM: busy=1. Each cycle: acc += code; update min_run/max_run; cnt++. acc is CW+LOG_SAMPLES bits and cannot overflow. After the 2^LOG_SAMPLES-th sample, go to DONE.
  - DONE: one cycle, busy=1, valid=1. Outputs are loaded: avg = acc >> LOG_SAMPLES (truncated), min_code = min_run, max_code = max_run.
    - If continuous=1 and en=1, go to ACCUM and clear acc, min_run, max_run, cnt and bubble_err. No flush; the DONE-cycle sample is discarded.
    - Otherwise go to IDLE.
- Timing: start high in cycle 0 from IDLE gives valid in cycle SYNC_STAGES+2+2^LOG_SAMPLES. Continuous mode gives a period of 2^LOG_SAMPLES+1 cycles.
- en=0 in any non-IDLE state: next state IDLE, busy=0 the next cycle, no valid. avg/min_code/max_code hold their previous values. bubble_err holds.
- start while busy: ignored. start held high in IDLE: retriggers each time IDLE is re-entered.
- continuous may change at any time; it is sampled only in DONE.
- LOG_SAMPLES=0: single sample, so avg=min_code=max_code=code.

Test Plan:
- Constant taps=16'h00FF; start pulse at cycle 0 (defaults) -> valid in cycle 20 only; avg=8, min_code=8, max_code=8, bubble_err=0; busy high cycles 1-20.
- Taps alternating 16'h000F / 16'h0FFF each cycle -> avg=8, min_code=4, max_code=12.
- Taps=16'hFFFF, then 16'h0000 -> code=16 after 3 cycles, then 0; full-scale avg=16 with no truncation error at CW=5.
- One ACCUM sample taps=16'h00F7, others 16'h00FF -> bubble_err=1 after valid; avg=7 (sum 127>>4); next start clears bubble_err.
- continuous=1, taps=16'h003F -> valid pulses every 17 cycles with avg=6; drop en mid-ACCUM -> busy=0 next cycle, no further valid, avg stays 6.
- Assert rst asynchronously mid-ACCUM -> all outputs 0 immediately; after release, start -> full flush before the first accumulated sample.
